// File: rtl/shake_squeeze.sv
// Squeeze-side reader: buffers the rate part of a permuted Keccak state and
// streams it one 64-bit lane per beat, asking the core for a new permutation per block.
module shake_squeeze #(
  parameter int RATE_BITS = 1344
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1599:0] state_in,
  input  logic          state_valid,
  output logic          state_ready,
  output logic [63:0]   out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          perm_req,
  input  logic          stop,
  output logic [7:0]    block_cnt
);

  localparam int LANES = RATE_BITS / 64;
  localparam int CW    = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_REQ    = 2'd2;
  localparam logic [1:0] S_WAIT   = 2'd3;

  logic [1:0]           r_state;
  logic [RATE_BITS-1:0] r_buffer;
  logic [CW-1:0]        r_laneCnt;
  logic [7:0]           r_blockCnt;

  logic [63:0] w_laneArr [LANES];
  logic [63:0] w_lane;
  logic        w_fire;
  logic        w_lastLane;

  for (genvar g = 0; g < LANES; g++) begin : g_lanes
    assign w_laneArr[g] = r_buffer[64*g +: 64];
  end

  assign w_lane     = w_laneArr[r_laneCnt];
  assign w_lastLane = (r_laneCnt == CW'(LANES - 1));
  assign w_fire     = (r_state == S_STREAM) && out_ready;

  // state_ready is masked by rst so it reads 0 while reset is held.
  assign state_ready = rst && ((r_state == S_IDLE) || (r_state == S_WAIT));
  assign out_valid   = (r_state == S_STREAM);
  assign out_data    = (r_state == S_STREAM) ? w_lane : 64'd0;
  assign out_last    = (r_state == S_STREAM) && w_lastLane;
  assign perm_req    = (r_state == S_REQ);
  assign block_cnt   = r_blockCnt;

  // stop is applied last so it overrides every other transition out of a busy state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_buffer   <= '0;
      r_laneCnt  <= '0;
      r_blockCnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (state_valid) begin
            r_buffer   <= state_in[RATE_BITS-1:0];
            r_laneCnt  <= '0;
            r_blockCnt <= '0;
            r_state    <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_fire) begin
            r_laneCnt <= r_laneCnt + CW'(1);
            if (w_lastLane) begin
              if (r_blockCnt != 8'hFF) begin
                r_blockCnt <= r_blockCnt + 8'd1;
              end
              r_state <= S_REQ;
            end
          end
          if (stop) begin
            r_state <= S_IDLE;
          end
        end
        S_REQ: begin
          r_state <= stop ? S_IDLE : S_WAIT;
        end
        S_WAIT: begin
          if (stop) begin
            r_state <= S_IDLE;
          end else if (state_valid) begin
            r_buffer  <= state_in[RATE_BITS-1:0];
            r_laneCnt <= '0;
            r_state   <= S_STREAM;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shake_squeeze.sv
// Directed bench for shake_squeeze: one SHAKE128-rate instance drives most cases,
// a second SHAKE256-rate instance covers the 17-lane block.
module tb_shake_squeeze;

  logic          clk;
  logic          rst;

  logic [1599:0] stateIn;
  logic          stateValid;
  logic          stateReady;
  logic [63:0]   outData;
  logic          outValid;
  logic          outReady;
  logic          outLast;
  logic          permReq;
  logic          stopIn;
  logic [7:0]    blockCnt;

  logic [1599:0] bStateIn;
  logic          bStateValid;
  logic          bStateReady;
  logic [63:0]   bOutData;
  logic          bOutValid;
  logic          bOutReady;
  logic          bOutLast;
  logic          bPermReq;
  logic          bStopIn;
  logic [7:0]    bBlockCnt;

  int checks;
  int failures;
  int reqCount;
  int bReqCount;

  shake_squeeze #(.RATE_BITS(1344)) u_dut (
    .clk(clk), .rst(rst),
    .state_in(stateIn), .state_valid(stateValid), .state_ready(stateReady),
    .out_data(outData), .out_valid(outValid), .out_ready(outReady), .out_last(outLast),
    .perm_req(permReq), .stop(stopIn), .block_cnt(blockCnt)
  );

  shake_squeeze #(.RATE_BITS(1088)) u_dut256 (
    .clk(clk), .rst(rst),
    .state_in(bStateIn), .state_valid(bStateValid), .state_ready(bStateReady),
    .out_data(bOutData), .out_valid(bOutValid), .out_ready(bOutReady), .out_last(bOutLast),
    .perm_req(bPermReq), .stop(bStopIn), .block_cnt(bBlockCnt)
  );

  // 10-time-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count perm_req pulses on the falling edge, well away from the output update
  initial begin
    reqCount  = 0;
    bReqCount = 0;
  end
  always @(negedge clk) begin
    if (permReq)  reqCount++;
    if (bPermReq) bReqCount++;
  end

  function automatic logic [63:0] laneVal(input int i, input int b);
    laneVal = ({16'hC0DE, 48'h0} | 64'(i)) ^ 64'(b);
  endfunction

  function automatic logic [1599:0] makeState(input int b);
    logic [1599:0] s;
    s = '0;
    for (int i = 0; i < 25; i++) s[64*i +: 64] = laneVal(i, b);
    makeState = s;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    rst         = 1'b0;
    stateIn     = '0;
    stateValid  = 1'b0;
    outReady    = 1'b0;
    stopIn      = 1'b0;
    bStateIn    = '0;
    bStateValid = 1'b0;
    bOutReady   = 1'b0;
    bStopIn     = 1'b0;
    repeat (2) stepCycle();
    rst = 1'b1;
  endtask

  task automatic applyStimulus(input logic [1599:0] st);
    stateIn    = st;
    stateValid = 1'b1;
    stepCycle();
    stateValid = 1'b0;
  endtask

  // Stream `count` beats of block `b` with out_ready held high
  task automatic streamBeats(input int b, input int first, input int count);
    outReady = 1'b1;
    for (int i = first; i < first + count; i++) begin
      checkOutput("beat_valid", 64'(outValid), 64'd1);
      checkOutput("beat_data", outData, laneVal(i, b));
      checkOutput("beat_last", 64'(outLast), 64'(i == 20));
      stepCycle();
    end
  endtask

  initial begin
    int r0;
    int expLane;
    int cyc;
    checks   = 0;
    failures = 0;
    rst      = 1'b0;

    // Test 1: reset state, then one full block at full throughput
    applyReset();
    rst = 1'b0;
    checkOutput("rst_state_ready", 64'(stateReady), 64'd0);
    checkOutput("rst_out_valid", 64'(outValid), 64'd0);
    checkOutput("rst_out_data", outData, 64'd0);
    checkOutput("rst_perm_req", 64'(permReq), 64'd0);
    checkOutput("rst_block_cnt", 64'(blockCnt), 64'd0);
    rst = 1'b1;
    #1;
    checkOutput("idle_state_ready", 64'(stateReady), 64'd1);
    r0 = reqCount;
    applyStimulus(makeState(0));
    checkOutput("stream_state_ready", 64'(stateReady), 64'd0);
    streamBeats(0, 0, 21);
    checkOutput("t1_req_pulse", 64'(permReq), 64'd1);
    checkOutput("t1_req_valid", 64'(outValid), 64'd0);
    checkOutput("t1_block_cnt", 64'(blockCnt), 64'd1);
    stepCycle();
    checkOutput("t1_req_drop", 64'(permReq), 64'd0);
    checkOutput("t1_wait_ready", 64'(stateReady), 64'd1);
    checkOutput("t1_wait_valid", 64'(outValid), 64'd0);
    repeat (3) stepCycle();
    checkOutput("t1_req_count", 64'(reqCount - r0), 64'd1);

    // Test 2: out_ready pattern 1,0,0 repeating; data must hold while stalled
    applyReset();
    applyStimulus(makeState(0));
    expLane = 0;
    cyc = 0;
    while (expLane < 21 && cyc < 200) begin
      outReady = (cyc % 3 == 0);
      checkOutput("t2_valid", 64'(outValid), 64'd1);
      checkOutput("t2_data", outData, laneVal(expLane, 0));
      stepCycle();
      if (outReady) expLane++;
      cyc++;
    end
    checkOutput("t2_all_lanes", 64'(expLane), 64'd21);
    checkOutput("t2_req_pulse", 64'(permReq), 64'd1);
    checkOutput("t2_block_cnt", 64'(blockCnt), 64'd1);

    // Test 3: three blocks, spurious state_valid during STREAM
    applyReset();
    r0 = reqCount;
    applyStimulus(makeState(0));
    for (int b = 0; b < 3; b++) begin
      outReady = 1'b1;
      for (int i = 0; i < 21; i++) begin
        checkOutput("t3_data", outData, laneVal(i, b));
        checkOutput("t3_last", 64'(outLast), 64'(i == 20));
        if (i == 3) begin
          stateIn    = '1;
          stateValid = 1'b1;
          checkOutput("t3_busy_ready", 64'(stateReady), 64'd0);
        end
        if (i == 6) stateValid = 1'b0;
        stepCycle();
      end
      checkOutput("t3_req_pulse", 64'(permReq), 64'd1);
      checkOutput("t3_block_cnt", 64'(blockCnt), 64'(b + 1));
      repeat (24) stepCycle();
      if (b < 2) applyStimulus(makeState(b + 1));
    end
    checkOutput("t3_req_count", 64'(reqCount - r0), 64'd3);
    checkOutput("t3_final_cnt", 64'(blockCnt), 64'd3);

    // Test 4: stop on lane 7 handshake, then stop on the last-lane handshake
    applyReset();
    r0 = reqCount;
    applyStimulus(makeState(0));
    streamBeats(0, 0, 7);
    checkOutput("t4_lane7", outData, laneVal(7, 0));
    stopIn = 1'b1;
    stepCycle();
    stopIn = 1'b0;
    checkOutput("t4_stop_valid", 64'(outValid), 64'd0);
    checkOutput("t4_stop_ready", 64'(stateReady), 64'd1);
    checkOutput("t4_stop_cnt", 64'(blockCnt), 64'd0);
    checkOutput("t4_stop_req", 64'(permReq), 64'd0);
    repeat (3) stepCycle();
    checkOutput("t4_no_req", 64'(reqCount - r0), 64'd0);
    applyStimulus(makeState(5));
    checkOutput("t4_restart_valid", 64'(outValid), 64'd1);
    checkOutput("t4_restart_lane0", outData, laneVal(0, 5));
    streamBeats(5, 0, 20);
    checkOutput("t4_last_lane", outData, laneVal(20, 5));
    stopIn = 1'b1;
    stepCycle();
    stopIn = 1'b0;
    checkOutput("t4_laststop_cnt", 64'(blockCnt), 64'd1);
    checkOutput("t4_laststop_req", 64'(permReq), 64'd0);
    checkOutput("t4_laststop_valid", 64'(outValid), 64'd0);
    repeat (3) stepCycle();
    checkOutput("t4_laststop_noreq", 64'(reqCount - r0), 64'd0);

    // Test 5: asynchronous reset in the middle of the second block
    applyReset();
    applyStimulus(makeState(0));
    streamBeats(0, 0, 21);
    repeat (2) stepCycle();
    applyStimulus(makeState(1));
    outReady = 1'b1;
    repeat (10) stepCycle();
    checkOutput("t5_lane10", outData, laneVal(10, 1));
    checkOutput("t5_cnt_before", 64'(blockCnt), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("t5_async_valid", 64'(outValid), 64'd0);
    checkOutput("t5_async_cnt", 64'(blockCnt), 64'd0);
    checkOutput("t5_async_data", outData, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("t5_idle_ready", 64'(stateReady), 64'd1);
    checkOutput("t5_idle_valid", 64'(outValid), 64'd0);

    // Test 6: 1088-bit rate gives 17 lanes per block
    applyReset();
    r0 = bReqCount;
    bStateIn    = makeState(2);
    bStateValid = 1'b1;
    stepCycle();
    bStateValid = 1'b0;
    bOutReady   = 1'b1;
    for (int i = 0; i < 17; i++) begin
      checkOutput("t6_valid", 64'(bOutValid), 64'd1);
      checkOutput("t6_data", bOutData, laneVal(i, 2));
      checkOutput("t6_last", 64'(bOutLast), 64'(i == 16));
      stepCycle();
    end
    checkOutput("t6_req_pulse", 64'(bPermReq), 64'd1);
    checkOutput("t6_block_cnt", 64'(bBlockCnt), 64'd1);
    checkOutput("t6_done_valid", 64'(bOutValid), 64'd0);
    repeat (2) stepCycle();
    checkOutput("t6_req_count", 64'(bReqCount - r0), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shake_squeeze.md
Name: shake_squeeze

Overview:
Squeeze-side reader for the SHAKE permutation core. It takes a permuted 1600-bit Keccak state and emits the rate portion one 64-bit lane per beat over a valid/ready stream. When the rate is exhausted it requests another permutation, which provides the XOF output stream for Kyber sampling (matrix A via SHAKE128, PRF/CBD via SHAKE256). It sits between the permutation core's state_out/valid and the rejection/CBD samplers.

Parameters:
RATE_BITS, 1344, squeeze rate in bits; 1344 for SHAKE128, 1088 for SHAKE256; must be a multiple of 64 and ≤1600.
LANES, RATE_BITS/64, derived value giving lanes per block (21 by default); not overridable.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
state_in  input  1600  permuted state; lane i = state_in[64*i+63 : 64*i], lane index = x+5y
state_valid  input  1  state_in holds a fresh permuted state
state_ready  output  1  block can capture a state this cycle
out_data  output  64  current squeezed lane
out_valid  output  1  out_data is valid
out_ready  input  1  consumer accepts out_data
out_last  output  1  current beat is lane LANES-1 of the block
perm_req  output  1  one-cycle pulse asking the core to permute again
stop  input  1  consumer has enough data; abort squeezing
block_cnt  output  8  number of blocks fully emitted, saturating at 255

Behaviour:
- Reset (rst=0, async): state=IDLE, state_ready=0, out_valid=0, out_last=0, out_data=0, perm_req=0, block_cnt=0, lane_cnt=0, buffer cleared.
- Buffer holds only state_in[RATE_BITS-1:0]. Capacity lanes are never output.
- FSM states are IDLE, STREAM, REQ and WAIT.
- IDLE: state_ready=1 (combinational from state). On state_valid: capture buffer, clear lane_cnt, clear block_cnt, go to STREAM.
- STREAM: out_valid=1, out_data=buffer lane lane_cnt, out_last=(lane_cnt==LANES-1).
  - On handshake (out_valid & out_ready): lane_cnt++.
  - If the handshake is on the last lane: block_cnt++ (saturating) and go to REQ.
  - out_data is stable while out_valid=1 and out_ready=0.
- REQ: perm_req=1 for exactly one cycle, out_valid=0, then go to WAIT.
- WAIT: state_ready=1. On state_valid: capture, clear lane_cnt, go to STREAM. block_cnt is retained.
- Latency: state captured at edge N gives out_valid=1 with lane 0 after edge N. Full throughput is one lane per cycle while out_ready=1.
- Block turnaround: last-lane handshake at edge M gives perm_req high during cycle M..M+1. Lane 0 of the next block appears no earlier than one cycle after the next accepted state_valid.
- stop is sampled on every edge in any non-IDLE state. It forces IDLE, out_valid=0, and no perm_req.
  - If stop coincides with a last-lane handshake, stop wins: that beat is consumed and block_cnt still increments, but there is no REQ.
  - If stop coincides with perm_req in REQ, the pulse already issued stands.
- state_valid is ignored in STREAM and REQ (state_ready=0).
- Async reset asserted mid-block discards the buffer immediately. Outputs drop within the reset, not at the next edge.

Test Plan:
1. Reset, RATE_BITS=1344, state_in lane i = 64'hC0DE_0000_0000_0000|i (all 25 lanes), state_valid pulse, out_ready=1 → 21 beats 64'hC0DE…0000 through 64'hC0DE…0014 on consecutive cycles. out_last only on 0x14. Then one perm_req pulse, block_cnt=1. Lanes 21–24 are never seen.
2. Same block, out_ready toggling 1,0,0,1,… → no lane dropped or duplicated, out_data held while stalled, final block_cnt=1.
3. Three back-to-back blocks, lane values XOR'd with block index, state_valid given 24 cycles after each perm_req → 63 beats in order, 3 perm_req pulses, block_cnt=3. state_valid during STREAM is ignored.
4. stop asserted at lane 7 handshake → that lane is consumed, FSM returns to IDLE, no perm_req, block_cnt=0. Next state_valid restarts at lane 0.
5. rst pulled low at lane 10 with out_valid=1 → out_valid and block_cnt drop to 0 asynchronously. After release the FSM is in IDLE with state_ready=1.
6. RATE_BITS=1088 → 17 beats per block, out_last on lane 16, perm_req follows.
